// File: rtl/matrix_writeback.sv
// matrix_writeback: AXI4 write master that drains a result stream into memory as fixed-size
// INCR bursts. Addresses follow the grouped scheme of the matrix read engine: the offset
// wraps modulo the group size inside a group, and the group base steps by the group size.
module matrix_writeback #(
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_start,
    input  logic [7:0][31:0]          i_control_reg,
    // Result stream
    input  logic [DATA_WIDTH-1:0]     i_s_data,
    input  logic                      i_s_valid,
    output logic                      o_s_ready,
    // AXI4 write-address channel
    output logic [ADDR_WIDTH-1:0]     o_m_axi_awaddr,
    output logic [7:0]                o_m_axi_awlen,
    output logic [2:0]                o_m_axi_awsize,
    output logic [1:0]                o_m_axi_awburst,
    output logic [0:0]                o_m_axi_awid,
    output logic [3:0]                o_m_axi_awcache,
    output logic [2:0]                o_m_axi_awprot,
    output logic                      o_m_axi_awvalid,
    input  logic                      i_m_axi_awready,
    // AXI4 write-data channel
    output logic [DATA_WIDTH-1:0]     o_m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_m_axi_wstrb,
    output logic                      o_m_axi_wlast,
    output logic                      o_m_axi_wvalid,
    input  logic                      i_m_axi_wready,
    // AXI4 write-response channel
    input  logic                      i_m_axi_bvalid,
    input  logic [1:0]                i_m_axi_bresp,
    output logic                      o_m_axi_bready,
    // Status words
    output logic [15:0][31:0]         o_status_reg
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                r_state;
    state_e                w_state_next;

    // Run parameters latched on start
    logic [ADDR_WIDTH-1:0] r_mask;
    logic [31:0]           r_burst_bytes;
    logic [31:0]           r_group_bytes;
    logic [31:0]           r_ops_per_group;
    logic [31:0]           r_total_ops;
    logic [31:0]           r_beats;

    // AW engine
    logic [ADDR_WIDTH-1:0] r_group_base;
    logic [ADDR_WIDTH-1:0] r_offset;
    logic [31:0]           r_grp_cnt;
    logic [31:0]           r_aw_count;

    // W engine
    logic [31:0]           r_w_bursts;
    logic [31:0]           r_beat_cnt;

    // B handling and run bookkeeping
    logic [31:0]           r_b_count;
    logic [31:0]           r_err_count;
    logic [31:0]           r_cycles;
    logic [31:0]           r_last_cycles;
    logic                  r_done_sticky;

    logic                  w_start_run;
    logic                  w_start_zero;
    logic                  w_busy;
    logic                  w_awvalid;
    logic                  w_aw_fire;
    logic                  w_w_active;
    logic                  w_w_fire;
    logic                  w_wlast;
    logic                  w_b_fire;
    logic [31:0]           w_outstanding;
    logic                  w_unused_ctrl;

    assign w_start_run   = (r_state == StIdle) && i_start && (i_control_reg[2] != 32'd0);
    assign w_start_zero  = (r_state == StIdle) && i_start && (i_control_reg[2] == 32'd0);
    assign w_outstanding = r_aw_count - r_b_count;
    assign w_aw_fire     = w_awvalid && i_m_axi_awready;
    assign w_wlast       = w_w_active && (r_beat_cnt == r_beats - 32'd1);
    assign w_w_fire      = w_w_active && i_s_valid && i_m_axi_wready;
    assign w_b_fire      = (r_state == StRun) && i_m_axi_bvalid;

    // Words 4, 6, 7 and the sub-beat bits of burst_bytes carry no meaning here
    assign w_unused_ctrl = ^{i_control_reg[7:6], i_control_reg[4], i_control_reg[3][5:0]};

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a run ends once every issued burst has been answered
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_start_run) w_state_next = StRun;
            StRun:   if (r_b_count == r_total_ops) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State-decoded outputs; gating on the state makes them drop as soon as reset asserts
    always_comb begin
        w_busy     = 1'b0;
        w_awvalid  = 1'b0;
        w_w_active = 1'b0;
        unique case (r_state)
            StRun: begin
                w_busy     = 1'b1;
                w_awvalid  = (r_aw_count < r_total_ops) &&
                             (w_outstanding < 32'(MAX_OUTSTANDING));
                // Registered aw_count: a same-cycle AW accept enables W one cycle later
                w_w_active = (r_w_bursts < r_aw_count);
            end
            StDone:  w_busy = 1'b1;
            default: ;
        endcase
    end

    // Latch the run parameters when a non-empty run starts
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_mask          <= '0;
            r_burst_bytes   <= '0;
            r_group_bytes   <= '0;
            r_ops_per_group <= '0;
            r_total_ops     <= '0;
            r_beats         <= '0;
        end else if (w_start_run) begin
            r_mask          <= ADDR_WIDTH'(i_control_reg[5] - 32'd1);
            r_burst_bytes   <= i_control_reg[3];
            r_group_bytes   <= i_control_reg[5];
            r_ops_per_group <= i_control_reg[1];
            r_total_ops     <= i_control_reg[2];
            r_beats         <= {6'd0, i_control_reg[3][31:6]};
        end
    end

    // AW engine: step the offset per burst, move to the next group after ops_per_group bursts
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_group_base <= '0;
            r_offset     <= '0;
            r_grp_cnt    <= '0;
            r_aw_count   <= '0;
        end else if (w_start_run) begin
            r_group_base <= ADDR_WIDTH'(i_control_reg[0]);
            r_offset     <= '0;
            r_grp_cnt    <= '0;
            r_aw_count   <= '0;
        end else if (w_aw_fire) begin
            r_aw_count <= r_aw_count + 32'd1;
            if (r_grp_cnt + 32'd1 == r_ops_per_group) begin
                r_group_base <= r_group_base + ADDR_WIDTH'(r_group_bytes);
                r_offset     <= '0;
                r_grp_cnt    <= '0;
            end else begin
                r_offset  <= r_offset + ADDR_WIDTH'(r_burst_bytes);
                r_grp_cnt <= r_grp_cnt + 32'd1;
            end
        end
    end

    // W engine: count beats within the burst and completed bursts
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_w_bursts <= '0;
            r_beat_cnt <= '0;
        end else if (w_start_run) begin
            r_w_bursts <= '0;
            r_beat_cnt <= '0;
        end else if (w_w_fire) begin
            if (w_wlast) begin
                r_beat_cnt <= '0;
                r_w_bursts <= r_w_bursts + 32'd1;
            end else begin
                r_beat_cnt <= r_beat_cnt + 32'd1;
            end
        end
    end

    // B responses: count every response and the non-OKAY ones separately
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_b_count   <= '0;
            r_err_count <= '0;
        end else if (w_start_run) begin
            r_b_count   <= '0;
            r_err_count <= '0;
        end else if (w_b_fire) begin
            r_b_count <= r_b_count + 32'd1;
            if (i_m_axi_bresp != 2'b00) begin
                r_err_count <= r_err_count + 32'd1;
            end
        end
    end

    // Run-cycle counter, last-run snapshot and sticky done flag
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cycles      <= '0;
            r_last_cycles <= '0;
            r_done_sticky <= 1'b0;
        end else begin
            if (w_start_run) begin
                r_cycles      <= '0;
                r_done_sticky <= 1'b0;
            end else if (r_state == StRun) begin
                r_cycles <= r_cycles + 32'd1;
            end
            if (w_start_zero) begin
                r_done_sticky <= 1'b1;
            end
            if (r_state == StDone) begin
                r_done_sticky <= 1'b1;
                r_last_cycles <= r_cycles;
            end
        end
    end

    // Status word map; unlisted words read zero
    always_comb begin
        o_status_reg    = '0;
        o_status_reg[0] = {31'd0, w_busy};
        o_status_reg[1] = r_aw_count;
        o_status_reg[2] = r_w_bursts;
        o_status_reg[3] = r_b_count;
        o_status_reg[4] = r_err_count;
        o_status_reg[5] = r_last_cycles;
        o_status_reg[6] = {31'd0, r_done_sticky};
    end

    assign o_m_axi_awaddr  = r_group_base + (r_offset & r_mask);
    assign o_m_axi_awlen   = 8'(r_beats - 32'd1);
    assign o_m_axi_awsize  = 3'b110;
    assign o_m_axi_awburst = 2'b01;
    assign o_m_axi_awid    = '0;
    assign o_m_axi_awcache = 4'b0000;
    assign o_m_axi_awprot  = 3'b010;
    assign o_m_axi_awvalid = w_awvalid;

    // Stream passes straight through onto W while a burst is active
    assign o_m_axi_wdata   = i_s_data;
    assign o_m_axi_wstrb   = '1;
    assign o_m_axi_wlast   = w_wlast;
    assign o_m_axi_wvalid  = w_w_active && i_s_valid;
    assign o_s_ready       = w_w_active && i_m_axi_wready;

    assign o_m_axi_bready  = 1'b1;

endmodule

// File: tb/tb_matrix_writeback.sv
// Bench for matrix_writeback: random AXI/stream handshakes against an arithmetic address model.
module tb_matrix_writeback;

    localparam int DW = 512;
    localparam int AW = 64;
    localparam int MO = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [7:0][31:0] ctrl = '0;
    logic [DW-1:0]    s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [AW-1:0]    awaddr;
    logic [7:0]       awlen;
    logic [2:0]       awsize;
    logic [1:0]       awburst;
    logic [0:0]       awid;
    logic [3:0]       awcache;
    logic [2:0]       awprot;
    logic             awvalid;
    logic             awready = 1'b0;
    logic [DW-1:0]    wdata;
    logic [DW/8-1:0]  wstrb;
    logic             wlast;
    logic             wvalid;
    logic             wready = 1'b0;
    logic             bvalid = 1'b0;
    logic [1:0]       bresp = 2'b00;
    logic             bready;
    logic [15:0][31:0] status;

    int errors = 0;
    int checks = 0;

    // Run configuration (written by the sequence only)
    int unsigned m_base, m_burst, m_group, m_opg, m_total, m_beats;
    int unsigned aw_pct, w_pct, sv_pct;
    int          b_delay, err_idx;
    logic        mon_en = 1'b0;
    int          clr_tok = 0;

    // Monitor state (written by the monitor only)
    int          clr_seen = 0;
    int          cyc = 0;
    int          aw_seen = 0, w_done_seen = 0, w_beat = 0, b_seen = 0, busy_cycles = 0;
    int          b_due[$];
    logic [1:0]  b_rsp[$];
    logic        data_used = 1'b0;

    matrix_writeback #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_start         (start),
        .i_control_reg   (ctrl),
        .i_s_data        (s_data),
        .i_s_valid       (s_valid),
        .o_s_ready       (s_ready),
        .o_m_axi_awaddr  (awaddr),
        .o_m_axi_awlen   (awlen),
        .o_m_axi_awsize  (awsize),
        .o_m_axi_awburst (awburst),
        .o_m_axi_awid    (awid),
        .o_m_axi_awcache (awcache),
        .o_m_axi_awprot  (awprot),
        .o_m_axi_awvalid (awvalid),
        .i_m_axi_awready (awready),
        .o_m_axi_wdata   (wdata),
        .o_m_axi_wstrb   (wstrb),
        .o_m_axi_wlast   (wlast),
        .o_m_axi_wvalid  (wvalid),
        .i_m_axi_wready  (wready),
        .i_m_axi_bvalid  (bvalid),
        .i_m_axi_bresp   (bresp),
        .o_m_axi_bready  (bready),
        .o_status_reg    (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Address of burst idx: group idx/opg, offset (k*burst) wrapped to the group size
    function automatic logic [63:0] exp_addr(input int unsigned idx);
        int unsigned grp;
        int unsigned k;
        grp = idx / m_opg;
        k   = idx % m_opg;
        return 64'(m_base) + 64'(grp) * 64'(m_group) + 64'((k * m_burst) & (m_group - 1));
    endfunction

    // Slave/source driver at negedge, then sample the handshakes due at the next posedge
    always @(negedge clk) begin
        if (clr_tok != clr_seen) begin
            clr_seen    = clr_tok;
            aw_seen     = 0;
            w_done_seen = 0;
            w_beat      = 0;
            b_seen      = 0;
            busy_cycles = 0;
            b_due.delete();
            b_rsp.delete();
        end
        if (!rstn) begin
            awready = 1'b0;
            wready  = 1'b0;
            s_valid = 1'b0;
            bvalid  = 1'b0;
            bresp   = 2'b00;
        end else begin
            cyc++;
            if (data_used) begin
                for (int k = 0; k < DW / 32; k++) s_data[32*k +: 32] = $urandom;
                data_used = 1'b0;
            end
            awready = ($urandom_range(99) < aw_pct);
            wready  = ($urandom_range(99) < w_pct);
            s_valid = ($urandom_range(99) < sv_pct);
            if (b_due.size() > 0 && b_due[0] <= cyc) begin
                bvalid = 1'b1;
                bresp  = b_rsp.pop_front();
                void'(b_due.pop_front());
            end else begin
                bvalid = 1'b0;
                bresp  = 2'b00;
            end
            #1;
            if (mon_en) begin
                if (status[0][0]) busy_cycles++;
                if (wvalid || s_ready) check("w_no_lead", 64'(w_done_seen < aw_seen), 64'd1);
                if (s_valid || wvalid)
                    check("w_s_handshake", 64'(wvalid && wready), 64'(s_valid && s_ready));
                if (wvalid && wready) begin
                    checks++;
                    assert (wdata === s_data) else begin
                        errors++;
                        $error("FAIL wdata: got %0h expected %0h", wdata[63:0], s_data[63:0]);
                    end
                    check("wstrb", 64'(wstrb), 64'hFFFF_FFFF_FFFF_FFFF);
                    check("wlast", 64'(wlast), 64'(w_beat == int'(m_beats) - 1));
                    data_used = 1'b1;
                    if (w_beat == int'(m_beats) - 1) begin
                        w_beat = 0;
                        b_due.push_back(cyc + b_delay);
                        b_rsp.push_back((w_done_seen == err_idx) ? 2'b10 : 2'b00);
                        w_done_seen++;
                    end else begin
                        w_beat++;
                    end
                end
                if (awvalid && awready) begin
                    check("aw_addr", awaddr, exp_addr(aw_seen));
                    check("aw_len", 64'(awlen), 64'(m_beats - 1));
                    check("aw_fixed", 64'({awsize, awburst, awid, awcache, awprot}),
                          64'(13'b110_01_0_0000_010));
                    check("aw_outstanding", 64'((aw_seen - b_seen) < MO), 64'd1);
                    check("aw_total", 64'(aw_seen < int'(m_total)), 64'd1);
                    aw_seen++;
                end
                if (bvalid) begin
                    check("bready", 64'(bready), 64'd1);
                    b_seen++;
                end
            end
        end
    end

    task automatic run(input int unsigned base, input int unsigned burst, input int unsigned group,
                       input int unsigned opg, input int unsigned total, input int unsigned awp,
                       input int unsigned wp, input int unsigned svp, input int bd, input int erri,
                       input bit poke_busy);
        m_base = base; m_burst = burst; m_group = group; m_opg = opg; m_total = total;
        m_beats = burst / 64;
        aw_pct = awp; w_pct = wp; sv_pct = svp; b_delay = bd; err_idx = erri;
        ctrl    = '0;
        ctrl[0] = base; ctrl[1] = opg; ctrl[2] = total; ctrl[3] = burst; ctrl[5] = group;
        clr_tok++;
        mon_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_clears_done", 64'(status[6]), 64'd0);
        if (poke_busy) begin
            repeat (3) @(negedge clk);
            ctrl[0] = 32'h9000;
            ctrl[2] = total + 5;
            start   = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("busy_during_poke", 64'(status[0]), 64'd1);
        end
        for (int i = 0; i < 5000 && !(status[6][0] && !status[0][0]); i++) @(negedge clk);
        check("run_done", 64'(status[6][0] && !status[0][0]), 64'd1);
        @(negedge clk);
        #2;
        check("st_aw_count", 64'(status[1]), 64'(total));
        check("st_w_bursts", 64'(status[2]), 64'(total));
        check("st_b_count", 64'(status[3]), 64'(total));
        check("st_err_count", 64'(status[4]), 64'((erri >= 0 && erri < int'(total)) ? 1 : 0));
        check("st_cycles", 64'(status[5]), 64'(busy_cycles - 1));
        check("seen_aw", 64'(aw_seen), 64'(total));
        check("seen_w", 64'(w_done_seen), 64'(total));
        check("seen_b", 64'(b_seen), 64'(total));
        mon_en = 1'b0;
    endtask

    initial begin
        m_opg = 1; m_group = 1; m_beats = 1;
        aw_pct = 0; w_pct = 0; sv_pct = 0; b_delay = 1; err_idx = -1;
        #3;
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_wvalid", 64'(wvalid), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        assert (status === '0) else begin
            errors++;
            $error("FAIL rst_status: got %0h expected 0", status);
        end

        // Single group, contiguous bursts, with a start pulse while busy
        run(32'h1000, 256, 4096, 4, 4, 100, 100, 100, 3, -1, 1'b1);
        // Group wrap and advance
        run(32'h0, 1024, 2048, 4, 8, 70, 80, 90, 2, -1, 1'b0);
        // Outstanding limit with slow B and throttled W
        run(32'h2_0000, 256, 4096, 16, 32, 100, 50, 100, 40, -1, 1'b0);
        // Error response on burst 3 of 5
        run(32'h4000, 512, 8192, 3, 5, 60, 70, 80, 4, 2, 1'b0);

        // Reset during burst 2
        m_base = 0; m_burst = 256; m_group = 4096; m_opg = 8; m_total = 8; m_beats = 4;
        aw_pct = 100; w_pct = 100; sv_pct = 100; b_delay = 5; err_idx = -1;
        ctrl    = '0;
        ctrl[1] = 8; ctrl[2] = 8; ctrl[3] = 256; ctrl[5] = 4096;
        clr_tok++;
        mon_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 300 && w_done_seen < 1; i++) @(negedge clk);
        check("reached_burst2", 64'(w_done_seen >= 1), 64'd1);
        @(negedge clk);
        mon_en = 1'b0;
        #2;
        check("pre_rst_wvalid", 64'(wvalid), 64'd1);
        rstn = 1'b0;
        #1;
        check("midrst_awvalid", 64'(awvalid), 64'd0);
        check("midrst_wvalid", 64'(wvalid), 64'd0);
        check("midrst_s_ready", 64'(s_ready), 64'd0);
        checks++;
        assert (status === '0) else begin
            errors++;
            $error("FAIL midrst_status: got %0h expected 0", status);
        end
        @(negedge clk);
        rstn = 1'b1;

        // Empty run: done_sticky set, nothing issued
        ctrl    = '0;
        ctrl[3] = 256; ctrl[5] = 4096;
        clr_tok++;
        mon_en = 1'b1;
        @(negedge clk);
        check("zero_pre_done", 64'(status[6]), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("zero_done", 64'(status[6]), 64'd1);
        check("zero_busy", 64'(status[0]), 64'd0);
        check("zero_aw_count", 64'(status[1]), 64'd0);
        check("zero_aw_seen", 64'(aw_seen), 64'd0);
        mon_en = 1'b0;

        // Clean run after reset, single-beat bursts
        run(32'h8000, 64, 256, 2, 6, 50, 50, 50, 1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
